// File: rtl/add32.sv
// Registered 32-bit adder (two-level carry lookahead); 1-cycle latency with o_valid tracking i_valid.
// No backpressure: a result is accepted every cycle; outputs hold while i_valid is low.
module add32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        i_carry,
   input  logic        i_valid,
   output logic [31:0] o_sum,
   output logic        o_carry,
   output logic        overflow,
   output logic        o_valid
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [7:0]  blk_g;
   logic [7:0]  blk_p;
   logic [8:0]  blk_c;
   logic [31:0] sum;
   logic        ovf;

   assign g = a & b;
   assign p = a ^ b;

   // first level: local carries of each 4-bit group expanded from its block carry-in
   for (genvar k = 0; k < 8; k++) begin : g_blk
      logic [3:0] gg;
      logic [3:0] pp;
      logic       ci;

      assign gg = g[4*k +: 4];
      assign pp = p[4*k +: 4];
      assign ci = blk_c[k];

      assign c[4*k]   = ci;
      assign c[4*k+1] = gg[0] | (pp[0] & ci);
      assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & ci);

      assign blk_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign blk_p[k] = &pp;
   end

   // second level: each block carry is a flat sum-of-products of group G/P and i_carry
   always_comb begin
      logic prod;
      logic acc;
      blk_c    = '0;
      blk_c[0] = i_carry;
      for (int k = 1; k <= 8; k++) begin
         acc  = 1'b0;
         for (int j = 0; j < k; j++) begin
            prod = blk_g[j];
            for (int m = j + 1; m < k; m++) prod = prod & blk_p[m];
            acc = acc | prod;
         end
         prod = i_carry;
         for (int m = 0; m < k; m++) prod = prod & blk_p[m];
         blk_c[k] = acc | prod;
      end
   end

   assign sum = p ^ c;
   assign ovf = c[31] ^ blk_c[8];

   always_ff @(posedge clk) begin
      if (rst) begin
         o_sum    <= '0;
         o_carry  <= 1'b0;
         overflow <= 1'b0;
         o_valid  <= 1'b0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_sum    <= sum;
            o_carry  <= blk_c[8];
            overflow <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_add32.sv
// Directed + random bench for add32 with an expected-result queue.
module tb_add32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        i_carry = 1'b0;
   logic        i_valid = 1'b0;
   logic [31:0] o_sum;
   logic        o_carry;
   logic        overflow;
   logic        o_valid;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
   } res_t;

   res_t q[$];
   res_t last = '0;
   int   total = 0;
   int   bad = 0;

   add32 dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .i_carry  (i_carry),
      .i_valid  (i_valid),
      .o_sum    (o_sum),
      .o_carry  (o_carry),
      .overflow (overflow),
      .o_valid  (o_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
      logic [32:0] f;
      res_t        r;
      f   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      r.s = f[31:0];
      r.c = f[32];
      r.v = (x[31] == y[31]) && (f[31] != x[31]);
      return r;
   endfunction

   task automatic step(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic vi, input string tag);
      res_t e;
      logic expv;
      a       = x;
      b       = y;
      i_carry = ci;
      i_valid = vi;
      @(posedge clk);
      expv = vi && !rst;
      if (rst) begin
         q.delete();
         last = '0;
      end else if (vi) begin
         q.push_back(model(x, y, ci));
      end
      #1;
      chk({tag, "_vld"}, {31'd0, o_valid}, {31'd0, expv});
      e = last;
      if (expv) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
         end else begin
            e    = q.pop_front();
            last = e;
         end
      end
      chk({tag, "_sum"}, o_sum, e.s);
      chk({tag, "_cry"}, {31'd0, o_carry}, {31'd0, e.c});
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.v});
   endtask

   initial begin
      // reset held with valid operands present
      rst = 1'b1;
      step(32'd5, 32'd7, 1'b0, 1'b1, "rst0");
      step(32'd5, 32'd7, 1'b0, 1'b1, "rst1");
      rst = 1'b0;
      step(32'd5, 32'd7, 1'b0, 1'b1, "first");
      chk("first_12", o_sum, 32'd12);

      step(32'd1, 32'd0, 1'b0, 1'b1, "b1");
      step(32'd1123, 32'd1312, 1'b1, 1'b1, "b2");
      chk("b2_2436", o_sum, 32'd2436);
      step(32'd123, 32'd421, 1'b1, 1'b1, "b3");
      step(32'd123, 32'd432, 1'b1, 1'b1, "b4");

      step(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, "wrap0");
      chk("wrap0_c", {31'd0, o_carry}, 32'd1);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "wrap1");
      step(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, "ovfp");
      chk("ovfp_v", {31'd0, overflow}, 32'd1);
      step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "ovfn");
      step(32'd10, ~32'd3, 1'b1, 1'b1, "sub");
      chk("sub_7", o_sum, 32'd7);
      step(32'h0000_FFFF, 32'd1, 1'b0, 1'b1, "cla");
      chk("cla_10000", o_sum, 32'h0001_0000);

      // hold while i_valid is low
      step(32'd1123, 32'd1312, 1'b1, 1'b1, "r2436");
      for (int i = 0; i < 3; i++)
         step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "hold");
      chk("hold_2436", o_sum, 32'd2436);

      // mid-stream reset discards the in-flight result
      step(32'd40, 32'd2, 1'b0, 1'b1, "pre");
      rst = 1'b1;
      step(32'd99, 32'd1, 1'b0, 1'b1, "midrst");
      rst = 1'b0;
      step(32'd3, 32'd4, 1'b0, 1'b1, "post");

      for (int i = 0; i < 10000; i++)
         step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, "rand");
      step(32'd0, 32'd0, 1'b0, 1'b0, "tail");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
